// File: rtl/rand_range_mapper_pkg.sv
// Shared game constants: LFSR word width, FSM encoding and per-use output ranges.
package rand_range_mapper_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRESH = 2'd1,
    REDUCE     = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam int GAME_RND_W   = 13;
  localparam int LANE_RANGE   = 4;
  localparam int COLUMN_RANGE = 40;
  localparam int ITEM_RANGE   = 12;

  // The remainder must fit OUT_W bits and the modulus must be reachable by the LFSR.
  function automatic bit range_legal(input int range, input int out_w, input int rnd_w);
    return (range >= 2) && (range <= (1 << out_w)) && (range <= (1 << rnd_w) - 1);
  endfunction

endpackage

// File: rtl/rand_range_mapper_mod_step.sv
// One restoring shift-subtract step: shifts a bit into the remainder and reduces it by RANGE.
module rand_range_mapper_mod_step #(
  parameter int RANGE = 40,
  parameter int OUT_W = 6
) (
  input  logic [OUT_W-1:0] rem_i,
  input  logic             bit_i,
  output logic [OUT_W-1:0] rem_o
);

  localparam logic [OUT_W:0] RANGE_V = (OUT_W+1)'(RANGE);

  logic [OUT_W:0] t;
  logic [OUT_W:0] sel;
  logic           unused_sel_msb;

  // rem_i < RANGE keeps t < 2*RANGE, so one conditional subtract restores the invariant.
  always_comb begin
    t   = {rem_i, bit_i};
    sel = (t >= RANGE_V) ? (t - RANGE_V) : t;
  end

  assign rem_o          = sel[OUT_W-1:0];
  assign unused_sel_msb = sel[OUT_W];

endmodule

// File: rtl/rand_range_mapper.sv
// Waits for an unused LFSR word, reduces it modulo RANGE one bit per clock, and offers it via valid/ack.
module rand_range_mapper
  import rand_range_mapper_pkg::*;
#(
  parameter int RND_W = GAME_RND_W,
  parameter int RANGE = COLUMN_RANGE,
  parameter int OUT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [RND_W-1:0] rnd_in,
  input  logic             req,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value_out,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(RND_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RND_W - 1);

  if (!range_legal(RANGE, OUT_W, RND_W)) begin : g_illegal_params
    $error("rand_range_mapper: illegal RANGE/OUT_W/RND_W combination");
  end

  state_t           state_q;
  logic [RND_W-1:0] shift_q;
  logic [RND_W-1:0] last_q;
  logic [OUT_W-1:0] rem_q;
  logic [OUT_W-1:0] rem_d;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] value_q;
  logic             busy_q;
  logic             valid_q;
  logic             fresh;

  assign fresh = (rnd_in != '0) && (rnd_in != last_q);

  rand_range_mapper_mod_step #(
    .RANGE (RANGE),
    .OUT_W (OUT_W)
  ) u_mod_step (
    .rem_i (rem_q),
    .bit_i (shift_q[RND_W-1]),
    .rem_o (rem_d)
  );

  // Handshake: req is a one-cycle strobe seen only in IDLE; valid stays high with
  // value_out stable until the cycle ack is sampled high, and ack is ignored otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= WAIT_FRESH;
            busy_q  <= 1'b1;
          end
        end
        WAIT_FRESH: begin
          if (fresh) begin
            shift_q <= rnd_in;
            last_q  <= rnd_in;
            rem_q   <= '0;
            cnt_q   <= LAST_BIT;
            state_q <= REDUCE;
          end
        end
        REDUCE: begin
          rem_q   <= rem_d;
          shift_q <= {shift_q[RND_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            value_q <= rem_d;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign valid     = valid_q;
  assign value_out = value_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rand_range_mapper.sv
// Directed bench for rand_range_mapper: RANGE=40 scenarios plus RANGE=2 / RANGE=64 LFSR sweeps.
module tb_rand_range_mapper;

  logic        clock;
  logic        reset;

  logic [12:0] m_rnd;
  logic        m_req, m_ack, m_busy, m_valid;
  logic [5:0]  m_val;
  logic [1:0]  m_st;

  logic [12:0] sw_rnd;
  logic        sw_req, sw_ack;
  logic        s2_busy, s2_valid, s64_busy, s64_valid;
  logic [0:0]  s2_val;
  logic [5:0]  s64_val;
  logic [1:0]  s2_st, s64_st;

  logic [5:0]  exp40_q[$];
  logic [0:0]  exp2_q[$];
  logic [5:0]  exp64_q[$];

  int n_vec = 0;
  int n_err = 0;

  rand_range_mapper #(.RND_W(13), .RANGE(40), .OUT_W(6)) dut (
    .clock(clock), .reset(reset), .rnd_in(m_rnd), .req(m_req), .ack(m_ack),
    .busy(m_busy), .valid(m_valid), .value_out(m_val), .dbg_state(m_st)
  );

  rand_range_mapper #(.RND_W(13), .RANGE(2), .OUT_W(1)) dut2 (
    .clock(clock), .reset(reset), .rnd_in(sw_rnd), .req(sw_req), .ack(sw_ack),
    .busy(s2_busy), .valid(s2_valid), .value_out(s2_val), .dbg_state(s2_st)
  );

  rand_range_mapper #(.RND_W(13), .RANGE(64), .OUT_W(6)) dut64 (
    .clock(clock), .reset(reset), .rnd_in(sw_rnd), .req(sw_req), .ack(sw_ack),
    .busy(s64_busy), .valid(s64_valid), .value_out(s64_val), .dbg_state(s64_st)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit (%0d vectors, %0d miscompares)", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [12:0] lfsr_next(input logic [12:0] l);
    return {l[11:0], l[12] ^ l[3] ^ l[2] ^ l[0]};
  endfunction

  task automatic pulse_req();
    m_req = 1'b1;
    @(negedge clock);
    m_req = 1'b0;
  endtask

  task automatic do_ack();
    m_ack = 1'b1;
    @(negedge clock);
    m_ack = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!m_valid && cyc < 100) begin
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic run_word(input logic [12:0] w, input logic [5:0] e, input string name);
    int cyc;
    m_rnd = w;
    exp40_q.push_back(e);
    pulse_req();
    wait_valid(cyc);
    chk({name, "_latency"}, 32'(cyc), 32'd14);
    do_ack();
  endtask

  // ---------------- monitors / scoreboard ----------------
  logic m_vp = 1'b0, s2_vp = 1'b0, s64_vp = 1'b0;

  always @(negedge clock) begin
    if (m_valid && !m_vp) begin
      if (exp40_q.size() == 0) chk("r40_unexpected_valid", 32'd1, 32'd0);
      else                     chk("r40_value", 32'(m_val), 32'(exp40_q.pop_front()));
    end
    if (s2_valid && !s2_vp) begin
      if (exp2_q.size() == 0) chk("r2_unexpected_valid", 32'd1, 32'd0);
      else                    chk("r2_value", 32'(s2_val), 32'(exp2_q.pop_front()));
    end
    if (s64_valid && !s64_vp) begin
      if (exp64_q.size() == 0) chk("r64_unexpected_valid", 32'd1, 32'd0);
      else                     chk("r64_value", 32'(s64_val), 32'(exp64_q.pop_front()));
    end
    m_vp   = m_valid;
    s2_vp  = s2_valid;
    s64_vp = s64_valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    int          cyc;
    int          bad;
    logic [12:0] lfsr;

    reset  = 1'b1;
    m_rnd  = '0; m_req = 1'b0; m_ack = 1'b0;
    sw_rnd = '0; sw_req = 1'b0; sw_ack = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_busy",  32'(m_busy),  32'd0);
    chk("reset_valid", 32'(m_valid), 32'd0);
    chk("reset_value", 32'(m_val),   32'd0);
    chk("reset_state", 32'(m_st),    32'd0);
    reset = 1'b0;
    @(negedge clock);

    // basic mapping: 100 mod 40 = 20
    m_rnd = 13'd100;
    exp40_q.push_back(6'd20);
    pulse_req();
    wait_valid(cyc);
    chk("basic_busy_cycles", 32'(cyc), 32'd14);
    chk("basic_busy_at_valid", 32'(m_busy), 32'd0);
    do_ack();
    chk("basic_valid_drop", 32'(m_valid), 32'd0);
    chk("basic_idle", 32'(m_st), 32'd0);
    chk("basic_value_kept", 32'(m_val), 32'd20);

    // boundary words
    run_word(13'd8191, 6'd31, "w8191");
    run_word(13'd40,   6'd0,  "w40");
    run_word(13'd39,   6'd39, "w39");
    run_word(13'd1,    6'd1,  "w1");

    // freshness: a repeated word and a zero word are never consumed
    run_word(13'd100, 6'd20, "w100");
    pulse_req();
    bad = 0;
    repeat (50) begin
      if (!m_busy || m_valid) bad++;
      @(negedge clock);
    end
    chk("fresh_repeat_held", 32'(bad), 32'd0);
    m_rnd = 13'd0;
    bad = 0;
    repeat (20) begin
      if (!m_busy || m_valid) bad++;
      @(negedge clock);
    end
    chk("fresh_zero_held", 32'(bad), 32'd0);
    m_rnd = 13'd4000;
    exp40_q.push_back(6'd0);
    wait_valid(cyc);
    chk("fresh_latency", 32'(cyc), 32'd14);
    do_ack();

    // reset during the 6th REDUCE cycle
    run_word(13'd123, 6'd3, "w123");
    m_rnd = 13'd500;
    pulse_req();
    repeat (6) @(negedge clock);
    chk("rst_pre_state", 32'(m_st), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_busy",  32'(m_busy),  32'd0);
    chk("rst_async_valid", 32'(m_valid), 32'd0);
    chk("rst_async_value", 32'(m_val),   32'd0);
    chk("rst_async_state", 32'(m_st),    32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_word(13'd77, 6'd37, "w77_after_reset");

    // handshake edges: 1234 mod 40 = 34
    m_rnd = 13'd1234;
    exp40_q.push_back(6'd34);
    pulse_req();
    wait_valid(cyc);
    chk("hold_latency", 32'(cyc), 32'd14);
    bad = 0;
    repeat (20) begin
      if (!m_valid || m_val != 6'd34) bad++;
      @(negedge clock);
    end
    chk("hold_stable", 32'(bad), 32'd0);
    m_rnd = 13'd3003;
    m_req = 1'b1;
    m_ack = 1'b1;
    @(negedge clock);
    m_req = 1'b0;
    m_ack = 1'b0;
    chk("reqack_valid_drop", 32'(m_valid), 32'd0);
    chk("reqack_idle", 32'(m_st), 32'd0);
    bad = 0;
    repeat (5) begin
      if (m_busy || m_st != 2'd0) bad++;
      @(negedge clock);
    end
    chk("reqack_no_start", 32'(bad), 32'd0);
    do_ack();
    chk("ack_idle_state", 32'(m_st), 32'd0);
    chk("ack_idle_valid", 32'(m_valid), 32'd0);
    chk("ack_idle_value", 32'(m_val), 32'd34);

    // extra req while reducing 3003 (mod 40 = 3) is ignored
    exp40_q.push_back(6'd3);
    pulse_req();
    repeat (4) @(negedge clock);
    pulse_req();
    wait_valid(cyc);
    chk("reduce_req_latency", 32'(cyc), 32'd9);
    do_ack();
    bad = 0;
    repeat (5) begin
      if (m_busy || m_valid) bad++;
      @(negedge clock);
    end
    chk("reduce_req_ignored", 32'(bad), 32'd0);

    // parameter sweep, RANGE=2 and RANGE=64, driven by the LFSR model
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    lfsr = 13'h1ACE;
    for (int i = 0; i < 200; i++) begin
      sw_req = 1'b1;
      @(negedge clock);
      sw_req = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      lfsr   = lfsr_next(lfsr);
      sw_rnd = lfsr;
      exp2_q.push_back(lfsr[0:0]);
      exp64_q.push_back(lfsr[5:0]);
      cyc = 0;
      while (!(s2_valid && s64_valid) && cyc < 60) begin
        cyc++;
        @(negedge clock);
      end
      chk("sweep_latency", 32'(cyc), 32'd14);
      sw_ack = 1'b1;
      @(negedge clock);
      sw_ack = 1'b0;
    end
    @(negedge clock);

    chk("r40_queue_empty", 32'(exp40_q.size()), 32'd0);
    chk("r2_queue_empty",  32'(exp2_q.size()),  32'd0);
    chk("r64_queue_empty", 32'(exp64_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
